// File: rtl/instruction_invalidation_queue_pkg.sv
// Shared types for the instruction-invalidation queue: the word-address type
// carried on both sides of the queue.
package instruction_invalidation_queue_pkg;

    localparam int INV_ADDR_W = 30;

    typedef logic [31:2] inv_addr_t;

endpackage

// File: rtl/instruction_invalidation_queue_if.sv
// Upstream request / downstream issue bundle of the invalidation queue.
// The queue takes the slave view; the producer/consumer side takes the master view.
interface instruction_invalidation_queue_if;
    import instruction_invalidation_queue_pkg::*;

    inv_addr_t in_inv_addr;
    logic      in_inv_valid;
    logic      in_inv_ready;
    logic      in_inv_outstanding;
    inv_addr_t out_inv_addr;
    logic      out_inv_valid;
    logic      out_inv_completed;
    logic      coalesced;

    modport slave (
        input  in_inv_addr,
        input  in_inv_valid,
        input  out_inv_completed,
        output in_inv_ready,
        output in_inv_outstanding,
        output out_inv_addr,
        output out_inv_valid,
        output coalesced
    );

    modport master (
        output in_inv_addr,
        output in_inv_valid,
        output out_inv_completed,
        input  in_inv_ready,
        input  in_inv_outstanding,
        input  out_inv_addr,
        input  out_inv_valid,
        input  coalesced
    );

endinterface

// File: rtl/instruction_invalidation_queue_inv_addr_fifo.sv
// Circular buffer of invalidation addresses with a head read port and a
// peek at the most recently pushed entry (tail-1) for duplicate merging.
module instruction_invalidation_queue_inv_addr_fifo
    import instruction_invalidation_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  inv_addr_t                push_addr_i,
    input  logic                     pop_i,
    output inv_addr_t                head_addr_o,
    output inv_addr_t                tail_addr_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);

    inv_addr_t       mem_q [DEPTH];
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   tail_q;
    logic [PW:0]     count_q;

    // Storage is deliberately left unreset; count_q qualifies every read.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[tail_q] <= push_addr_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                tail_q <= tail_q + PTR_ONE;
            end
            if (pop_i) begin
                head_q <= head_q + PTR_ONE;
            end
            unique case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_addr_o = mem_q[head_q];
    assign tail_addr_o = mem_q[tail_q - PTR_ONE];
    assign count_o     = count_q;

endmodule

// File: rtl/instruction_invalidation_queue.sv
// Invalidation request queue: buffers producer requests, issues them one at a
// time to the consumer and merges a repeat of the newest not-yet-issued address.
module instruction_invalidation_queue
    import instruction_invalidation_queue_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter bit COALESCE = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    instruction_invalidation_queue_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);
    localparam logic [PW:0] ONE_COUNT  = (PW + 1)'(1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    inv_addr_t   out_addr_q, out_addr_d;
    logic        coalesced_q, coalesced_d;

    logic [PW:0] count;
    inv_addr_t   head_addr;
    inv_addr_t   tail_addr;
    logic        accept;
    logic        tail_in_flight;
    logic        coalesce_hit;
    logic        push;
    logic        pop;

    assign bus.in_inv_ready = (count != FULL_COUNT);
    assign accept           = bus.in_inv_valid & bus.in_inv_ready;

    // The newest entry is only in flight when it is also the only entry.
    assign tail_in_flight = (count == ONE_COUNT) && (state_q == ACTIVE);
    assign coalesce_hit   = COALESCE && accept && (count != '0) &&
                            (bus.in_inv_addr == tail_addr) && !tail_in_flight;
    assign push           = accept && !coalesce_hit;
    assign pop            = (state_q == ACTIVE) && bus.out_inv_completed;

    instruction_invalidation_queue_inv_addr_fifo #(
        .DEPTH (DEPTH)
    ) u_inv_addr_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_addr_i (bus.in_inv_addr),
        .pop_i       (pop),
        .head_addr_o (head_addr),
        .tail_addr_o (tail_addr),
        .count_o     (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            out_addr_q  <= '0;
            coalesced_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_addr_q  <= out_addr_d;
            coalesced_q <= coalesced_d;
        end
    end

    // A completion seen in IDLE is ignored, so a stray pulse after reset is harmless.
    always_comb begin
        state_d     = state_q;
        out_addr_d  = out_addr_q;
        coalesced_d = coalesce_hit;
        unique case (state_q)
            IDLE: begin
                if (count != '0) begin
                    out_addr_d = head_addr;
                    state_d    = ACTIVE;
                end
            end
            ACTIVE: begin
                if (bus.out_inv_completed) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.out_inv_valid      = (state_q == ACTIVE);
    assign bus.out_inv_addr       = out_addr_q;
    assign bus.coalesced          = coalesced_q;
    assign bus.in_inv_outstanding = (count != '0);

endmodule

// File: tb/tb_instruction_invalidation_queue.sv
// Scoreboard bench: stimulus pushes expected issue addresses, a negedge monitor
// pops and compares on every new issue; timing points are checked inline.
module tb_instruction_invalidation_queue;
    import instruction_invalidation_queue_pkg::*;

    localparam int WAIT_LIMIT = 64;

    logic clk;
    logic rst;
    logic mirror_en;
    logic stray_ok;

    int tests = 0;
    int fails = 0;
    int coal_seen = 0;
    int coal0_seen = 0;

    inv_addr_t exp_q[$];
    inv_addr_t exp0_q[$];

    logic      prev_valid;
    logic      prev0_valid;
    inv_addr_t prev_addr;

    instruction_invalidation_queue_if bus ();
    instruction_invalidation_queue_if bus0 ();

    instruction_invalidation_queue #(.DEPTH(4), .COALESCE(1'b1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    instruction_invalidation_queue #(.DEPTH(4), .COALESCE(1'b0)) u_dut_nc (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    // The non-merging instance sees the same requests only while mirroring is on.
    assign bus0.in_inv_valid = bus.in_inv_valid & mirror_en;
    assign bus0.in_inv_addr  = bus.in_inv_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endfunction

    // Auto consumer for the non-merging instance: completes in the first valid cycle.
    initial begin
        bus0.out_inv_completed = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus0.out_inv_completed = bus0.out_inv_valid && !bus0.out_inv_completed;
        end
    end

    always @(negedge clk) begin
        if (bus.coalesced) coal_seen <= coal_seen + 1;
        if (bus0.coalesced) coal0_seen <= coal0_seen + 1;
        if (!rst) begin
            prev_valid  <= 1'b0;
            prev0_valid <= 1'b0;
        end else begin
            if (bus.out_inv_valid && !prev_valid) begin
                $display("[TB] issue dut=merge addr=0x%0h", bus.out_inv_addr);
                check("issue_addr", 32'(bus.out_inv_addr),
                      exp_q.size() != 0 ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF);
            end
            if (bus.out_inv_valid && prev_valid)
                check("addr_stable", 32'(bus.out_inv_addr), 32'(prev_addr));
            if (bus.out_inv_completed && !stray_ok)
                check("completion_only_while_valid", 32'(bus.out_inv_valid), 32'd1);
            if (bus0.out_inv_valid && !prev0_valid) begin
                $display("[TB] issue dut=nomerge addr=0x%0h", bus0.out_inv_addr);
                check("issue_addr_nomerge", 32'(bus0.out_inv_addr),
                      exp0_q.size() != 0 ? 32'(exp0_q.pop_front()) : 32'hDEAD_BEEF);
            end
            prev_valid  <= bus.out_inv_valid;
            prev0_valid <= bus0.out_inv_valid;
            prev_addr   <= bus.out_inv_addr;
        end
    end

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic send(input inv_addr_t a, input bit expect_issue);
        int n;
        n = 0;
        bus.in_inv_valid = 1'b1;
        bus.in_inv_addr  = a;
        if (expect_issue) exp_q.push_back(a);
        while (!bus.in_inv_ready && n < WAIT_LIMIT) begin
            @(posedge clk); #1; n++;
        end
        check("send_ready_bound", 32'(n < WAIT_LIMIT), 32'd1);
        @(posedge clk); #1;
        bus.in_inv_valid = 1'b0;
    endtask

    task automatic complete();
        int n;
        n = 0;
        while (!bus.out_inv_valid && n < WAIT_LIMIT) begin
            @(posedge clk); #1; n++;
        end
        check("complete_valid_bound", 32'(n < WAIT_LIMIT), 32'd1);
        bus.out_inv_completed = 1'b1;
        @(posedge clk); #1;
        bus.out_inv_completed = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"},       32'(bus.in_inv_ready),       32'd1);
        check({tag, "_outstanding"}, 32'(bus.in_inv_outstanding), 32'd0);
        check({tag, "_valid"},       32'(bus.out_inv_valid),      32'd0);
        check({tag, "_addr"},        32'(bus.out_inv_addr),       32'd0);
        check({tag, "_coalesced"},   32'(bus.coalesced),          32'd0);
    endtask

    // Single request with cycle-exact checks; entered at cycle 0 (+1 unit).
    task automatic single_request(input inv_addr_t a, input string tag);
        bus.in_inv_valid = 1'b1;
        bus.in_inv_addr  = a;
        exp_q.push_back(a);
        @(negedge clk);
        check({tag, "_c0_ready"},       32'(bus.in_inv_ready),       32'd1);
        check({tag, "_c0_outstanding"}, 32'(bus.in_inv_outstanding), 32'd0);
        @(posedge clk); #1;
        bus.in_inv_valid = 1'b0;
        @(negedge clk);
        check({tag, "_c1_outstanding"}, 32'(bus.in_inv_outstanding), 32'd1);
        check({tag, "_c1_valid"},       32'(bus.out_inv_valid),      32'd0);
        @(negedge clk);
        check({tag, "_c2_valid"},       32'(bus.out_inv_valid),      32'd1);
        check({tag, "_c2_addr"},        32'(bus.out_inv_addr),       32'(a));
        repeat (3) @(posedge clk);
        #1;
        bus.out_inv_completed = 1'b1;
        @(negedge clk);
        check({tag, "_c5_valid"},       32'(bus.out_inv_valid),      32'd1);
        @(posedge clk); #1;
        bus.out_inv_completed = 1'b0;
        @(negedge clk);
        check({tag, "_c6_valid"},       32'(bus.out_inv_valid),      32'd0);
        check({tag, "_c6_outstanding"}, 32'(bus.in_inv_outstanding), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst                   = 1'b0;
        mirror_en             = 1'b0;
        stray_ok              = 1'b0;
        bus.in_inv_valid      = 1'b0;
        bus.in_inv_addr       = '0;
        bus.out_inv_completed = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("por");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Single request 0x1000 >> 2.
        single_request(30'h400, "single");

        // Five back-to-back, no completions until full.
        for (int i = 0; i < 4; i++) send(30'h10 + 30'(i), 1'b1);
        bus.in_inv_valid      = 1'b1;
        bus.in_inv_addr       = 30'h14;
        exp_q.push_back(30'h14);
        bus.out_inv_completed = 1'b1;
        @(negedge clk);
        check("full_ready_low", 32'(bus.in_inv_ready), 32'd0);
        @(posedge clk); #1;
        bus.out_inv_completed = 1'b0;
        @(negedge clk);
        check("ready_after_pop", 32'(bus.in_inv_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_inv_valid = 1'b0;
        repeat (4) complete();

        // Duplicate of a queued (not in-flight) entry merges once.
        mirror_en = 1'b1;
        exp0_q.push_back(30'h100);
        exp0_q.push_back(30'h123);
        exp0_q.push_back(30'h123);
        send(30'h100, 1'b1);
        send(30'h123, 1'b1);
        send(30'h123, 1'b0);
        mirror_en = 1'b0;
        @(negedge clk);
        check("coalesced_pulse", 32'(bus.coalesced), 32'd1);
        @(negedge clk);
        check("coalesced_one_cycle", 32'(bus.coalesced), 32'd0);
        @(posedge clk); #1;
        repeat (2) complete();
        check("coalesce_count_merge", 32'(coal_seen), 32'd1);

        // Duplicate of the in-flight entry enqueues.
        send(30'h200, 1'b1);
        @(posedge clk); #1;
        check("inflight_valid", 32'(bus.out_inv_valid), 32'd1);
        send(30'h200, 1'b1);
        repeat (2) complete();
        check("coalesce_count_inflight", 32'(coal_seen), 32'd1);

        // Push and completion together at count 2, wrapping the pointers.
        send(30'h300, 1'b1);
        send(30'h301, 1'b1);
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!bus.out_inv_valid && n < WAIT_LIMIT) begin
                @(posedge clk); #1; n++;
            end
            check("pushpop_valid_bound", 32'(n < WAIT_LIMIT), 32'd1);
            bus.in_inv_valid      = 1'b1;
            bus.in_inv_addr       = 30'h302 + 30'(i);
            exp_q.push_back(30'h302 + 30'(i));
            bus.out_inv_completed = 1'b1;
            @(posedge clk); #1;
            bus.in_inv_valid      = 1'b0;
            bus.out_inv_completed = 1'b0;
        end
        send(30'h310, 1'b1);
        send(30'h311, 1'b1);
        @(negedge clk);
        check("pushpop_count_kept_full", 32'(bus.in_inv_ready), 32'd0);
        check("pushpop_outstanding", 32'(bus.in_inv_outstanding), 32'd1);
        @(posedge clk); #1;
        repeat (4) complete();

        // Asynchronous reset while a request is in flight with three entries.
        send(30'h500, 1'b1);
        send(30'h501, 1'b0);
        send(30'h502, 1'b0);
        check("pre_reset_valid", 32'(bus.out_inv_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(posedge clk); #1;
        rst = 1'b1;
        stray_ok              = 1'b1;
        bus.out_inv_completed = 1'b1;
        @(posedge clk); #1;
        bus.out_inv_completed = 1'b0;
        stray_ok              = 1'b0;
        @(negedge clk);
        check("stray_valid", 32'(bus.out_inv_valid), 32'd0);
        check("stray_outstanding", 32'(bus.in_inv_outstanding), 32'd0);
        check("stray_ready", 32'(bus.in_inv_ready), 32'd1);
        @(posedge clk); #1;
        single_request(30'h600, "post_rst");

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("scoreboard_nomerge_drained", 32'(exp0_q.size()), 32'd0);
        check("coalesce_total", 32'(coal_seen), 32'd1);
        check("nomerge_never_coalesces", 32'(coal0_seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instruction_invalidation_queue.md
# instruction_invalidation_queue

Buffers word-addressed instruction-invalidation requests between a producer (store path / coherence source) and a single instruction-side consumer (I-cache / fetch-buffer invalidation logic). Upstream side is the sink modport of `instruction_invalidation_interface`; downstream side is the source modport of `instruction_invalidation_queued`. The block issues requests one at a time, holds each until the consumer signals completion, and merges back-to-back duplicate addresses.

## Interface
Parameters:
- `DEPTH`, 4, queue entries; power of two, ≥2
- `COALESCE`, 1, 1 = merge an incoming address equal to the newest not-yet-issued entry

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `in_inv_addr`  in  30  word address [31:2] of upstream request
- `in_inv_valid`  in  1  upstream request valid
- `in_inv_ready`  out  1  queue can accept (count != DEPTH)
- `in_inv_outstanding`  out  1  any entry queued or in flight
- `out_inv_addr`  out  30  address presented to consumer
- `out_inv_valid`  out  1  request in flight; held until completion
- `out_inv_completed`  in  1  one-cycle pulse: consumer finished current request
- `coalesced`  out  1  one-cycle pulse: accepted request merged, not enqueued

## Operation
- Circular buffer of DEPTH × 30 b; head/tail pointers log2(DEPTH) b, wrap naturally; `count` 0..DEPTH (log2(DEPTH)+1 b).
- Accept = `in_inv_valid & in_inv_ready`. `in_inv_ready` depends only on `count`, never on `in_inv_valid`/addr.
- Coalesce hit (COALESCE=1): accept & count>0 & addr == entry[tail-1] & that entry not in flight (not (count==1 & state==ACTIVE)). On hit: no push, `coalesced`=1 next cycle. Match against the in-flight entry always enqueues.
- Issue FSM, two states:
  - IDLE: `out_inv_valid`=0. If count>0: load `out_inv_addr` ← entry[head], → ACTIVE.
  - ACTIVE: `out_inv_valid`=1, `out_inv_addr` stable. On `out_inv_completed`: pop head, → IDLE.
- `out_inv_completed` in IDLE: ignored (protocol violation; bench asserts it never happens).
- Push and pop in same cycle: count unchanged; both pointers advance.
- Full: `in_inv_ready`=0; pop in that cycle does not raise ready until next cycle (ready from registered count).
- `in_inv_outstanding` = (count != 0); in-flight entry stays in buffer until popped.
- Reset (any time, incl. mid-request): pointers, count = 0; state IDLE; in-flight and queued requests discarded; a later stray completion is ignored.
- Reset values: `in_inv_ready`=1, `in_inv_outstanding`=0, `out_inv_valid`=0, `out_inv_addr`=0, `coalesced`=0. Storage array not reset.

## Timing
- Accept in cycle 0 into empty queue → `in_inv_outstanding`=1 in cycle 1, `out_inv_valid`=1 in cycle 2.
- Completion pulse in cycle k → `out_inv_valid`=0 and count decremented in k+1; next queued entry valid in k+2. Minimum one idle cycle between requests.
- `coalesced` asserted exactly one cycle, cycle after accepting handshake.
- Sustained throughput: one request per (consumer latency + 2) cycles.

## Structure
- `inv_addr_t` (logic [31:2]) goes in `cva5_types`; FSM enum local to module.
- One sub-module natural: `inv_addr_fifo` (circular buffer with tail-1 peek port, count, push/pop); FSM and coalesce compare stay in top.

## Test plan
- Reset release, single request 0x0000_1000>>2 accepted cycle 0 → `out_inv_valid` cycle 2, addr 0x400; completion cycle 5 → valid low cycle 6, `in_inv_outstanding` low cycle 6.
- Five distinct addresses back-to-back, consumer never completes, DEPTH=4 → four accepted, `in_inv_ready`=0 after 4th; one completion → ready=1 one cycle later, 5th accepted; issue order matches push order.
- Duplicate addr 0x123 sent twice while first still queued behind in-flight 0x100 → `coalesced` pulse once, only two issues (0x100, 0x123); with COALESCE=0 → three issues.
- Duplicate of in-flight addr 0x200 → enqueued, issued twice, no `coalesced`.
- Push and completion same cycle with count=2 → count stays 2, pointers wrap after 4+ ops with correct addresses.
- `rst` asserted while ACTIVE with 3 entries → all outputs at reset values asynchronously; stray completion after release ignored; new request issues normally at cycle 2.
